// File: rtl/prime_pkg.sv
// rtl/prime_pkg.sv - shared types and constants for the prime stream reader
package prime_pkg;

    localparam int PRIME_W = 32;
    localparam int TIMER_W = 12;

    localparam logic [1:0] ADDR_MAX   = 2'b00;
    localparam logic [1:0] ADDR_TABLE = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MAX,
        ST_WAIT_RESP,
        ST_WAIT_DONE,
        ST_RD_ISSUE,
        ST_RD_EVAL,
        ST_EMIT,
        ST_FINISH,
        ST_FAIL
    } prime_rd_state_t;

endpackage

// File: rtl/prime_timeout_cnt.sv
// rtl/prime_timeout_cnt.sv - wait-state watchdog counter with clear, enable and expired flag
module prime_timeout_cnt #(
    parameter int LIMIT = 4096,
    parameter int W     = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt;

    // expired is seen during the LIMIT-th enabled cycle so the owner leaves exactly LIMIT cycles after entry
    assign expired = (cnt == W'(LIMIT - 1));

    // count enabled cycles, freeze once expired, restart on clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prime_stream_reader.sv
// rtl/prime_stream_reader.sv - Avalon-MM reader of the prime table, re-emitted as a valid/ready stream
module prime_stream_reader
    import prime_pkg::*;
#(
    parameter int MAX_PRIMES     = 256,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [9:0]         max_value,
    output logic               gen_write,
    output logic [1:0]         gen_address,
    output logic [PRIME_W-1:0] gen_writedata,
    input  logic [PRIME_W-1:0] gen_readdata,
    input  logic [1:0]         gen_response,
    input  logic               gen_writeresponsevalid,
    input  logic               gen_done,
    output logic [PRIME_W-1:0] prime_data,
    output logic               prime_valid,
    input  logic               prime_ready,
    output logic               prime_last,
    output logic               busy,
    output logic               finished,
    output logic               error,
    output logic [8:0]         prime_count
);

    localparam int IDX_W = (MAX_PRIMES > 1) ? $clog2(MAX_PRIMES) : 1;
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MAX_PRIMES - 1);
    localparam logic [8:0]       COUNT_MAX = 9'(MAX_PRIMES);

    prime_rd_state_t state, state_n;

    logic [IDX_W-1:0]   idx, idx_n;
    logic [PRIME_W-1:0] hold, hold_n;
    logic               hold_valid, hold_valid_n;
    logic [PRIME_W-1:0] rd_data, rd_data_n;
    logic               tail, tail_n;
    logic [9:0]         max_q, max_n;
    logic [LAT_W-1:0]   lat, lat_n;
    logic [8:0]         count_n;
    logic               error_n;
    logic               gen_write_n;
    logic [1:0]         gen_address_n;
    logic [PRIME_W-1:0] gen_writedata_n;
    logic [PRIME_W-1:0] data_n;
    logic               valid_n;
    logic               last_n;
    logic               busy_n;
    logic               finished_n;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;
    logic rd_zero;
    logic at_last;

    assign tmo_clear  = (state_n != state);
    assign tmo_enable = (state == ST_WAIT_RESP) || (state == ST_WAIT_DONE);
    assign rd_zero    = (rd_data == '0);
    assign at_last    = (idx == LAST_IDX);

    prime_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TIMER_W)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // state, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            hold          <= '0;
            hold_valid    <= 1'b0;
            rd_data       <= '0;
            tail          <= 1'b0;
            max_q         <= '0;
            lat           <= '0;
            prime_count   <= '0;
            error         <= 1'b0;
            gen_write     <= 1'b0;
            gen_address   <= ADDR_MAX;
            gen_writedata <= '0;
            prime_data    <= '0;
            prime_valid   <= 1'b0;
            prime_last    <= 1'b0;
            busy          <= 1'b0;
            finished      <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            hold          <= hold_n;
            hold_valid    <= hold_valid_n;
            rd_data       <= rd_data_n;
            tail          <= tail_n;
            max_q         <= max_n;
            lat           <= lat_n;
            prime_count   <= count_n;
            error         <= error_n;
            gen_write     <= gen_write_n;
            gen_address   <= gen_address_n;
            gen_writedata <= gen_writedata_n;
            prime_data    <= data_n;
            prime_valid   <= valid_n;
            prime_last    <= last_n;
            busy          <= busy_n;
            finished      <= finished_n;
        end
    end

    // next-state, datapath updates, and output values decoded from the next state
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        hold_n       = hold;
        hold_valid_n = hold_valid;
        rd_data_n    = rd_data;
        tail_n       = tail;
        max_n        = max_q;
        lat_n        = '0;
        count_n      = prime_count;
        error_n      = error;
        data_n       = prime_data;
        last_n       = prime_last;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n      = ST_WR_MAX;
                    max_n        = max_value;
                    error_n      = 1'b0;
                    count_n      = '0;
                    idx_n        = '0;
                    hold_valid_n = 1'b0;
                    tail_n       = 1'b0;
                end
            end
            ST_WR_MAX: begin
                state_n = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (gen_writeresponsevalid) begin
                    state_n = (gen_response == RESP_OKAY) ? ST_WAIT_DONE : ST_FAIL;
                end else if (tmo_expired) begin
                    state_n = ST_FAIL;
                end
            end
            ST_WAIT_DONE: begin
                if (gen_done) begin
                    state_n = ST_RD_ISSUE;
                end else if (tmo_expired) begin
                    state_n = ST_FAIL;
                end
            end
            ST_RD_ISSUE: begin
                if (lat == LAT_W'(READ_LATENCY - 1)) begin
                    rd_data_n = gen_readdata;
                    state_n   = ST_RD_EVAL;
                end else begin
                    lat_n = lat + 1'b1;
                end
            end
            ST_RD_EVAL: begin
                if (tail) begin
                    // final table entry was already read; it sits in hold and closes the list
                    data_n  = hold;
                    last_n  = 1'b1;
                    tail_n  = 1'b0;
                    state_n = ST_EMIT;
                end else if (!hold_valid) begin
                    if (rd_zero) begin
                        state_n = ST_FINISH;
                    end else if (at_last) begin
                        hold_n       = rd_data;
                        hold_valid_n = 1'b1;
                        data_n       = rd_data;
                        last_n       = 1'b1;
                        state_n      = ST_EMIT;
                    end else begin
                        hold_n       = rd_data;
                        hold_valid_n = 1'b1;
                        idx_n        = idx + 1'b1;
                        state_n      = ST_RD_ISSUE;
                    end
                end else begin
                    data_n  = hold;
                    last_n  = rd_zero;
                    state_n = ST_EMIT;
                    if (!rd_zero) begin
                        hold_n = rd_data;
                        tail_n = at_last;
                    end
                end
            end
            ST_EMIT: begin
                if (prime_valid && prime_ready) begin
                    if (prime_count != COUNT_MAX) begin
                        count_n = prime_count + 9'd1;
                    end
                    if (prime_last) begin
                        state_n = ST_FINISH;
                    end else if (tail) begin
                        state_n = ST_RD_EVAL;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = ST_RD_ISSUE;
                    end
                end
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            ST_FAIL: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (state_n == ST_FAIL) begin
            error_n = 1'b1;
        end

        gen_write_n     = (state_n == ST_WR_MAX);
        gen_address_n   = (state_n == ST_RD_ISSUE) ? ADDR_TABLE : ADDR_MAX;
        gen_writedata_n = '0;
        if (state_n == ST_WR_MAX) begin
            gen_writedata_n = PRIME_W'(max_n);
        end else if (state_n == ST_RD_ISSUE) begin
            gen_writedata_n = PRIME_W'(idx_n);
        end

        valid_n = (state_n == ST_EMIT);
        if (!valid_n) begin
            data_n = '0;
            last_n = 1'b0;
        end

        busy_n     = (state_n != ST_IDLE);
        finished_n = (state_n == ST_FINISH);
    end

endmodule

// File: tb/tb_prime_stream_reader.sv
// tb/tb_prime_stream_reader.sv - scoreboard bench for prime_stream_reader with a behavioural generator model
module tb_prime_stream_reader;

    localparam int MAXP = 16;
    localparam int RL   = 2;
    localparam int TMO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  max_value;
    logic        gen_write;
    logic [1:0]  gen_address;
    logic [31:0] gen_writedata;
    logic [31:0] gen_readdata;
    logic [1:0]  gen_response;
    logic        gen_writeresponsevalid;
    logic        gen_done;
    logic [31:0] prime_data;
    logic        prime_valid;
    logic        prime_ready;
    logic        prime_last;
    logic        busy;
    logic        finished;
    logic        error;
    logic [8:0]  prime_count;

    prime_stream_reader #(
        .MAX_PRIMES     (MAXP),
        .READ_LATENCY   (RL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
        .max_value              (max_value),
        .gen_write              (gen_write),
        .gen_address            (gen_address),
        .gen_writedata          (gen_writedata),
        .gen_readdata           (gen_readdata),
        .gen_response           (gen_response),
        .gen_writeresponsevalid (gen_writeresponsevalid),
        .gen_done               (gen_done),
        .prime_data             (prime_data),
        .prime_valid            (prime_valid),
        .prime_ready            (prime_ready),
        .prime_last             (prime_last),
        .busy                   (busy),
        .finished               (finished),
        .error                  (error),
        .prime_count            (prime_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    int     exp_q[$];
    int     fin_cnt   = 0;
    int     beat_cnt  = 0;
    int     wr_count  = 0;
    int     wr_data   = 0;
    int     model_max = 0;
    int     cfg_resp  = 0;
    bit     cfg_done  = 1'b1;
    bit     stall_mode = 1'b0;
    logic [31:0] stall_data;
    bit     stalled = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int nth_prime(input int mx, input int i);
        int k = 0;
        for (int n = 2; n <= mx; n++) begin
            if (is_prime(n)) begin
                if (k == i) return n;
                k++;
            end
        end
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // generator model: two-cycle read pipeline, write response and done flag after fixed delays
    initial begin
        int rd_pipe;
        int resp_wait;
        int done_wait;
        rd_pipe = 0; resp_wait = 0; done_wait = 0;
        gen_readdata = '0; gen_response = '0; gen_writeresponsevalid = 1'b0; gen_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            gen_readdata = rd_pipe;
            rd_pipe = (gen_address == 2'b01 && int'(gen_writedata) < MAXP)
                      ? nth_prime(model_max, int'(gen_writedata)) : 0;
            gen_writeresponsevalid = 1'b0;
            if (resp_wait > 0) begin
                resp_wait--;
                if (resp_wait == 0) begin
                    gen_writeresponsevalid = 1'b1;
                    gen_response = 2'(cfg_resp);
                end
            end
            if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) gen_done = 1'b1;
            end
            if (gen_write && gen_address == 2'b00) begin
                wr_count++;
                wr_data   = int'(gen_writedata);
                model_max = int'(gen_writedata);
                gen_done  = 1'b0;
                resp_wait = 2;
                done_wait = cfg_done ? 5 : 0;
            end
        end
    end

    // ready driver: always ready, or hold ready low for 5 cycles of valid before each beat
    initial begin
        int stall_cnt;
        stall_cnt = 0;
        prime_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (!stall_mode) begin
                prime_ready = 1'b1;
            end else if (prime_ready) begin
                prime_ready = 1'b0;
                stall_cnt = 0;
            end else if (prime_valid) begin
                stall_cnt++;
                if (stall_cnt >= 5) prime_ready = 1'b1;
            end
        end
    end

    // scoreboard and stall-stability monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (finished) fin_cnt++;
            if (prime_valid && prime_ready) begin
                beat_cnt++;
                stalled = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", prime_data, 0);
                end else begin
                    chk("data", prime_data, exp_q.pop_front());
                    chk("last", prime_last, exp_q.size() == 0);
                end
            end else if (prime_valid) begin
                if (stalled) chk("stall_data", prime_data, stall_data);
                stalled = 1'b1;
                stall_data = prime_data;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(tag, {gen_write, gen_address, gen_writedata, prime_valid, prime_last,
                  busy, finished, error, prime_count}, 0);
        chk({tag, "_data"}, prime_data, 0);
    endtask

    task automatic do_start(input int mx);
        @(negedge clk);
        start = 1'b1;
        max_value = 10'(mx);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
        chk("idle", busy, 0);
    endtask

    task automatic run_ok(input int mx, input bit stall, input int exp_cnt);
        int fb, wb, bb;
        stall_mode = stall;
        for (int i = 0; i < MAXP; i++) begin
            int p;
            p = nth_prime(mx, i);
            if (p == 0) break;
            exp_q.push_back(p);
        end
        fb = fin_cnt; wb = wr_count; bb = beat_cnt;
        do_start(mx);
        wait_idle();
        chk("wr_count", wr_count - wb, 1);
        chk("wr_data", wr_data, mx);
        chk("finished", fin_cnt - fb, 1);
        chk("beats", beat_cnt - bb, exp_cnt);
        chk("prime_count", prime_count, exp_cnt);
        chk("error", error, 0);
        chk("sb_empty", exp_q.size(), 0);
        stall_mode = 1'b0;
    endtask

    initial begin
        int fb, wb, entry, errc;
        reset = 1'b1; start = 1'b0; max_value = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        run_ok(10, 1'b0, 4);
        run_ok(1, 1'b0, 0);
        run_ok(30, 1'b1, 10);
        run_ok(60, 1'b0, 16);
        run_ok(100, 1'b1, 16);

        // bad write response
        cfg_resp = 1;
        fb = fin_cnt;
        do_start(10);
        wait_idle();
        chk("resp_error", error, 1);
        chk("resp_no_finish", fin_cnt - fb, 0);
        chk("resp_count", prime_count, 0);
        cfg_resp = 0;
        do_start(10);
        chk("err_clear", error, 0);
        exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(7);
        fb = fin_cnt;
        wait_idle();
        chk("recover_finish", fin_cnt - fb, 1);
        chk("recover_count", prime_count, 4);

        // done never arrives; a start while busy must be ignored
        cfg_done = 1'b0;
        fb = fin_cnt; wb = wr_count;
        do_start(12);
        entry = -1; errc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = (i == 5);
            max_value = 10'd20;
            if (gen_writeresponsevalid && entry < 0) entry = cyc + 1;
            if (error) begin errc = cyc; break; end
        end
        start = 1'b0;
        chk("timeout_cycles", errc - entry, TMO);
        wait_idle();
        chk("timeout_no_finish", fin_cnt - fb, 0);
        chk("busy_start_ignored", wr_count - wb, 1);
        chk("busy_start_data", wr_data, 12);
        cfg_done = 1'b1;

        // reset in the middle of a table read
        do_start(10);
        for (int i = 0; i < 100 && gen_address != 2'b01; i++) @(negedge clk);
        chk("saw_rd_issue", gen_address, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        reset = 1'b0;
        exp_q.delete();
        run_ok(10, 1'b0, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
